// File: rtl/synth_pkg.sv
// Shared types, configuration register map and helpers for the polyphonic voice engine.
package synth_pkg;

  // Per-voice envelope generator state.
  typedef enum logic [2:0] {
    ENV_IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } env_state_t;

  // Oscillator waveform selection (low two bits of the shape register).
  typedef enum logic [1:0] {
    SAW,
    SQUARE,
    TRI,
    SILENT
  } shape_t;

  // Sample sweep sequencer states.
  typedef enum logic [1:0] {
    SW_IDLE,
    SW_SWEEP,
    SW_DRAIN
  } sweep_state_t;

  // Configuration register map (cfg_addr).
  localparam logic [2:0] CFG_FREQ  = 3'd0;
  localparam logic [2:0] CFG_AMP   = 3'd1;
  localparam logic [2:0] CFG_SHAPE = 3'd2;
  localparam logic [2:0] CFG_A     = 3'd3;
  localparam logic [2:0] CFG_D     = 3'd4;
  localparam logic [2:0] CFG_S     = 3'd5;
  localparam logic [2:0] CFG_R     = 3'd6;

  // Clamp a wide signed mix value into the signed 16-bit sample range.
  function automatic logic signed [15:0] sat_s16(input logic signed [31:0] i_x);
    if (i_x > 32'sd32767) begin
      return 16'sh7FFF;
    end else if (i_x < -32'sd32768) begin
      return 16'sh8000;
    end else begin
      return i_x[15:0];
    end
  endfunction

endpackage

// File: rtl/poly_voice_engine_if.sv
// Control/config/sample bus of the voice engine: the controller drives ticks,
// gates and register writes, the engine returns the mixed sample and status.
interface poly_voice_engine_if #(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 24,
  parameter int OUT_W      = 16
);
  localparam int VW = $clog2(NUM_VOICES);

  logic                    sample_tick;
  logic [NUM_VOICES-1:0]   key_on;
  logic                    cfg_we;
  logic [VW-1:0]           cfg_voice;
  logic [2:0]              cfg_addr;
  logic [PHASE_W-1:0]      cfg_data;
  logic signed [OUT_W-1:0] out;
  logic                    out_valid;
  logic                    busy;
  logic                    overrun;

  modport master (
    output sample_tick, key_on, cfg_we, cfg_voice, cfg_addr, cfg_data,
    input  out, out_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, key_on, cfg_we, cfg_voice, cfg_addr, cfg_data,
    output out, out_valid, busy, overrun
  );

endinterface

// File: rtl/adsr_step.sv
// One combinational step of a linear ADSR envelope for a single voice slot.
module adsr_step
  import synth_pkg::*;
#(
  parameter int W = 16
) (
  input  env_state_t     i_state,
  input  logic [W-1:0]   i_env,
  input  logic           i_gate_rise,
  input  logic           i_gate,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_d,
  input  logic [W-1:0]   i_s,
  input  logic [W-1:0]   i_r,
  output env_state_t     o_state,
  output logic [W-1:0]   o_env
);

  env_state_t   w_eff;
  logic [W:0]   w_up;
  logic [W:0]   w_dn_d;
  logic [W:0]   w_dn_r;

  // One extra bit catches attack overflow and decay/release underflow.
  assign w_up   = {1'b0, i_env} + {1'b0, i_a};
  assign w_dn_d = {1'b0, i_env} - {1'b0, i_d};
  assign w_dn_r = {1'b0, i_env} - {1'b0, i_r};

  // Gate events override the stored state before the rate step is applied.
  always_comb begin
    if (i_gate_rise) begin
      w_eff = ATTACK;
    end else if (!i_gate && (i_state == ATTACK || i_state == DECAY || i_state == SUSTAIN)) begin
      w_eff = RELEASE;
    end else begin
      w_eff = i_state;
    end
  end

  // Rate step; a zero rate holds both the level and the state.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    o_state = w_eff;
    o_env   = i_env;
    case (w_eff)
      ATTACK: begin
        if (i_a != '0) begin
          if (w_up >= {1'b0, {W{1'b1}}}) begin
            o_env   = '1;
            o_state = DECAY;
          end else begin
            o_env = w_up[W-1:0];
          end
        end
      end
      DECAY: begin
        if (i_d != '0) begin
          if (w_dn_d[W] || (w_dn_d[W-1:0] <= i_s)) begin
            o_env   = i_s;
            o_state = SUSTAIN;
          end else begin
            o_env = w_dn_d[W-1:0];
          end
        end
      end
      SUSTAIN: begin
        o_env = i_s;
      end
      RELEASE: begin
        if (i_r != '0) begin
          if (w_dn_r[W] || (w_dn_r[W-1:0] == '0)) begin
            o_env   = '0;
            o_state = ENV_IDLE;
          end else begin
            o_env = w_dn_r[W-1:0];
          end
        end
      end
      default: begin
        o_env   = '0;
        o_state = ENV_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/poly_voice_engine.sv
// Time-multiplexed polyphonic synthesis core: one shared 3-stage datapath sweeps
// all voices per sample tick and mixes them with saturation into one sample.
module poly_voice_engine
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 24,
  parameter int OUT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  poly_voice_engine_if.slave    bus
);

  localparam int              VW        = $clog2(NUM_VOICES);
  localparam int              ACC_W     = OUT_W + VW;
  localparam logic [VW-1:0]   LAST_SLOT = VW'(NUM_VOICES - 1);

  // Per-voice configuration
  logic [PHASE_W-1:0]  r_freq  [NUM_VOICES];
  logic [OUT_W-1:0]    r_amp   [NUM_VOICES];
  shape_t              r_shape [NUM_VOICES];
  logic [OUT_W-1:0]    r_a     [NUM_VOICES];
  logic [OUT_W-1:0]    r_d     [NUM_VOICES];
  logic [OUT_W-1:0]    r_s     [NUM_VOICES];
  logic [OUT_W-1:0]    r_r     [NUM_VOICES];

  // Per-voice running state
  logic [PHASE_W-1:0]  r_phase  [NUM_VOICES];
  logic [OUT_W-1:0]    r_env    [NUM_VOICES];
  env_state_t          r_env_st [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_key_prev;

  // Sweep sequencer
  sweep_state_t   r_state, w_state_next;
  logic [VW-1:0]  r_slot;
  logic [1:0]     r_drain;
  logic           w_start;
  logic           w_s1_active;
  logic           r_overrun;

  // Stage 1 signals and pipeline registers
  logic [PHASE_W-1:0]      w_phase_new;
  logic [15:0]             w_p;
  logic [14:0]             w_tri_t;
  logic signed [OUT_W-1:0] w_wave;
  logic                    w_gate;
  logic                    w_rise;
  env_state_t              w_env_st_next;
  logic [OUT_W-1:0]        w_env_next;
  logic                    r_s1_valid, r_s1_last;
  logic signed [OUT_W-1:0] r_s1_wave;
  logic [OUT_W-1:0]        r_s1_env;
  logic [OUT_W-1:0]        r_s1_amp;

  // Stage 2/3 signals and registers
  logic signed [2*OUT_W:0] w_prod1, w_prod2;
  logic signed [OUT_W-1:0] w_m1, w_m2;
  logic                    r_s2_valid, r_s2_last;
  logic signed [OUT_W-1:0] r_s2_m1;
  logic [OUT_W-1:0]        r_s2_amp;
  logic signed [ACC_W-1:0] r_acc, w_acc_sum;
  logic signed [OUT_W-1:0] r_out;
  logic                    r_out_valid;

  // Sweep state, slot counter and drain counter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_reset_n) begin
      r_state <= SW_IDLE;
      r_slot  <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_next;
      r_slot  <= w_s1_active ? r_slot + 1'b1 : '0;
      r_drain <= (r_state == SW_DRAIN) ? r_drain + 2'd1 : 2'd0;
    end
  end

  // Next state: tick starts a sweep, one slot per cycle, then three drain cycles.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_s1_active  = 1'b0;
    case (r_state)
      SW_IDLE: begin
        if (bus.sample_tick) begin
          w_state_next = SW_SWEEP;
          w_start      = 1'b1;
        end
      end
      SW_SWEEP: begin
        w_s1_active = 1'b1;
        if (r_slot == LAST_SLOT) w_state_next = SW_DRAIN;
      end
      SW_DRAIN: begin
        if (r_drain == 2'd2) w_state_next = SW_IDLE;
      end
      default: w_state_next = SW_IDLE;
    endcase
  end

  // Sticky overrun: any tick that arrives outside IDLE is dropped and flagged.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overrun <= 1'b0;
    end else if (bus.sample_tick && (r_state != SW_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  // Configuration register writes from the host.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: these arrays are reset because a voice must start silent; that keeps them in flops, not RAM.
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_freq[i]  <= '0;
        r_amp[i]   <= '0;
        r_shape[i] <= SAW;
        r_a[i]     <= '0;
        r_d[i]     <= '0;
        r_s[i]     <= '0;
        r_r[i]     <= '0;
      end
    end else if (bus.cfg_we) begin
      case (bus.cfg_addr)
        CFG_FREQ:  r_freq[bus.cfg_voice]  <= bus.cfg_data;
        CFG_AMP:   r_amp[bus.cfg_voice]   <= bus.cfg_data[OUT_W-1:0];
        CFG_SHAPE: r_shape[bus.cfg_voice] <= shape_t'(bus.cfg_data[1:0]);
        CFG_A:     r_a[bus.cfg_voice]     <= bus.cfg_data[OUT_W-1:0];
        CFG_D:     r_d[bus.cfg_voice]     <= bus.cfg_data[OUT_W-1:0];
        CFG_S:     r_s[bus.cfg_voice]     <= bus.cfg_data[OUT_W-1:0];
        CFG_R:     r_r[bus.cfg_voice]     <= bus.cfg_data[OUT_W-1:0];
        default: ;
      endcase
    end
  end

  // Stage 1: phase advance and waveform lookup from the updated phase.
  assign w_phase_new = r_phase[r_slot] + r_freq[r_slot];
  assign w_p         = w_phase_new[PHASE_W-1 -: 16];
  assign w_tri_t     = w_p[15] ? ~w_p[14:0] : w_p[14:0];
  assign w_gate      = bus.key_on[r_slot];
  assign w_rise      = w_gate & ~r_key_prev[r_slot];

  // Waveform generator for the voice in stage 1.
  always_comb begin
    w_wave = '0;
    case (r_shape[r_slot])
      SAW:     w_wave = {~w_p[15], w_p[14:0]};
      SQUARE:  w_wave = w_p[15] ? 16'sh8000 : 16'sh7FFF;
      TRI:     w_wave = {w_tri_t, 1'b0} ^ 16'h8000;
      default: w_wave = '0;
    endcase
  end

  adsr_step #(.W(OUT_W)) u_adsr (
    .i_state     (r_env_st[r_slot]),
    .i_env       (r_env[r_slot]),
    .i_gate_rise (w_rise),
    .i_gate      (w_gate),
    .i_a         (r_a[r_slot]),
    .i_d         (r_d[r_slot]),
    .i_s         (r_s[r_slot]),
    .i_r         (r_r[r_slot]),
    .o_state     (w_env_st_next),
    .o_env       (w_env_next)
  );

  // Stage 1 writeback of phase, envelope and gate history for the active slot.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_phase[i]  <= '0;
        r_env[i]    <= '0;
        r_env_st[i] <= ENV_IDLE;
      end
      r_key_prev <= '0;
    end else if (w_s1_active) begin
      r_phase[r_slot]    <= w_phase_new;
      r_env[r_slot]      <= w_env_next;
      r_env_st[r_slot]   <= w_env_st_next;
      r_key_prev[r_slot] <= w_gate;
    end
  end

  // Stage 2/3 arithmetic: signed wave times unsigned env/amp, floor-shifted by 16.
  assign w_prod1   = $signed(r_s1_wave) * $signed({1'b0, r_s1_env});
  assign w_m1      = OUT_W'(w_prod1 >>> OUT_W);
  assign w_prod2   = $signed(r_s2_m1) * $signed({1'b0, r_s2_amp});
  assign w_m2      = OUT_W'(w_prod2 >>> OUT_W);
  assign w_acc_sum = r_acc + {{VW{w_m2[OUT_W-1]}}, w_m2};

  // Pipeline registers between stages; amp travels with the voice it was read for.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_wave  <= '0;
      r_s1_env   <= '0;
      r_s1_amp   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_m1    <= '0;
      r_s2_amp   <= '0;
    end else begin
      r_s1_valid <= w_s1_active;
      r_s1_last  <= w_s1_active && (r_slot == LAST_SLOT);
      r_s1_wave  <= w_wave;
      r_s1_env   <= w_env_next;
      r_s1_amp   <= r_amp[r_slot];
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_m1    <= w_m1;
      r_s2_amp   <= r_s1_amp;
    end
  end

  // Stage 3 mix accumulator and saturated output sample.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_start) begin
        r_acc <= '0;
      end else if (r_s2_valid) begin
        r_acc <= w_acc_sum;
      end
      if (r_s2_valid && r_s2_last) begin
        r_out       <= sat_s16(32'(w_acc_sum));
        r_out_valid <= 1'b1;
      end
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_state != SW_IDLE);
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_poly_voice_engine.sv
// Self-checking bench for poly_voice_engine: directed scenarios plus randomized
// configuration/gate traffic compared against an arithmetic voice model.
module tb_poly_voice_engine;

  localparam int N  = 4;
  localparam int VW = 2;

  localparam int M_IDLE = 0;
  localparam int M_ATT  = 1;
  localparam int M_DEC  = 2;
  localparam int M_SUS  = 3;
  localparam int M_REL  = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  poly_voice_engine_if #(.NUM_VOICES(N), .PHASE_W(24), .OUT_W(16)) bus ();

  poly_voice_engine #(.NUM_VOICES(N), .PHASE_W(24), .OUT_W(16)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int m_freq [N];
  int m_amp  [N];
  int m_shape[N];
  int m_a    [N];
  int m_d    [N];
  int m_s    [N];
  int m_r    [N];
  int m_phase[N];
  int m_env  [N];
  int m_st   [N];
  bit m_prev [N];

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int v = 0; v < N; v++) begin
      m_freq[v] = 0; m_amp[v] = 0; m_shape[v] = 0;
      m_a[v] = 0; m_d[v] = 0; m_s[v] = 0; m_r[v] = 0;
      m_phase[v] = 0; m_env[v] = 0; m_st[v] = M_IDLE; m_prev[v] = 1'b0;
    end
  endfunction

  function automatic void model_cfg(input int v, input int addr, input int data);
    case (addr)
      0: m_freq[v]  = data % (1 << 24);
      1: m_amp[v]   = data % 65536;
      2: m_shape[v] = data % 4;
      3: m_a[v]     = data % 65536;
      4: m_d[v]     = data % 65536;
      5: m_s[v]     = data % 65536;
      6: m_r[v]     = data % 65536;
      default: ;
    endcase
  endfunction

  function automatic void model_env(input int v, input bit gate, input bit rise);
    int e  = m_env[v];
    int st = m_st[v];
    if (rise) st = M_ATT;
    else if (!gate && (st == M_ATT || st == M_DEC || st == M_SUS)) st = M_REL;
    case (st)
      M_ATT: if (m_a[v] != 0) begin
        e = e + m_a[v];
        if (e >= 65535) begin e = 65535; st = M_DEC; end
      end
      M_DEC: if (m_d[v] != 0) begin
        e = e - m_d[v];
        if (e <= m_s[v]) begin e = m_s[v]; st = M_SUS; end
      end
      M_SUS: e = m_s[v];
      M_REL: if (m_r[v] != 0) begin
        e = e - m_r[v];
        if (e <= 0) begin e = 0; st = M_IDLE; end
      end
      default: e = 0;
    endcase
    m_env[v] = e;
    m_st[v]  = st;
  endfunction

  // Expected mixed sample for one sweep with the given gate levels.
  function automatic int model_sweep(input bit [N-1:0] keys);
    longint acc = 0;
    for (int v = 0; v < N; v++) begin
      int     p;
      int     wave;
      int     t;
      longint m1;
      longint m2;
      bit     rise;
      m_phase[v] = (m_phase[v] + m_freq[v]) % (1 << 24);
      p = m_phase[v] / 256;
      case (m_shape[v])
        0: wave = p - 32768;
        1: wave = (p >= 32768) ? -32768 : 32767;
        2: begin
          t    = (p < 32768) ? p : 65535 - p;
          wave = 2 * t - 32768;
        end
        default: wave = 0;
      endcase
      rise      = keys[v] && !m_prev[v];
      m_prev[v] = keys[v];
      model_env(v, keys[v], rise);
      m1  = (longint'(wave) * longint'(m_env[v])) >>> 16;
      m2  = (m1 * longint'(m_amp[v])) >>> 16;
      acc = acc + m2;
    end
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.sample_tick = 1'b0;
    bus.key_on      = '0;
    bus.cfg_we      = 1'b0;
    bus.cfg_voice   = '0;
    bus.cfg_addr    = '0;
    bus.cfg_data    = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    model_reset();
  endtask

  task automatic cfg_write(input int v, input int addr, input int data);
    bus.cfg_we    = 1'b1;
    bus.cfg_voice = VW'(v);
    bus.cfg_addr  = 3'(addr);
    bus.cfg_data  = 24'(data);
    step();
    bus.cfg_we = 1'b0;
    model_cfg(v, addr, data);
  endtask

  // One tick, then check busy/out_valid every cycle and the sample at cycle N+3.
  task automatic run_sweep(input string tag, input int exp);
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    for (int c = 1; c <= N + 3; c++) begin
      check({tag, ".busy"}, bus.busy, 1);
      check({tag, ".valid"}, bus.out_valid, (c == N + 3));
      if (c == N + 3) check({tag, ".out"}, bus.out, exp);
      else step();
    end
    step();
    check({tag, ".busy_end"}, bus.busy, 0);
    check({tag, ".valid_end"}, bus.out_valid, 0);
    check({tag, ".out_hold"}, bus.out, exp);
  endtask

  task automatic setup_voice0_saw();
    cfg_write(0, 0, 24'h010000);
    cfg_write(0, 2, 0);
    cfg_write(0, 1, 16'hFFFF);
    cfg_write(0, 3, 16'hFFFF);
  endtask

  initial begin
    int c;
    int exp_rel[6];
    n_vec = 0;
    n_err = 0;

    // Reset state
    do_reset();
    check("rst.out", bus.out, 0);
    check("rst.valid", bus.out_valid, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.overrun", bus.overrun, 0);

    // Single saw voice with instant attack
    setup_voice0_saw();
    bus.key_on = 4'b0001;
    run_sweep("saw1", -32512);

    // Four full-scale squares saturate the mix
    do_reset();
    for (int v = 0; v < N; v++) begin
      cfg_write(v, 0, 24'h000100);
      cfg_write(v, 2, 1);
      cfg_write(v, 1, 16'hFFFF);
      cfg_write(v, 3, 16'hFFFF);
    end
    bus.key_on = 4'b1111;
    run_sweep("sq_sat", 32767);

    // Attack, decay to sustain, then release to idle
    do_reset();
    cfg_write(0, 0, 24'h000100);
    cfg_write(0, 2, 1);
    cfg_write(0, 1, 16'hFFFF);
    cfg_write(0, 3, 16'hFFFF);
    cfg_write(0, 4, 16'hFFFF);
    cfg_write(0, 5, 16'h8000);
    cfg_write(0, 6, 16'h4000);
    exp_rel = '{32765, 16382, 16382, 8190, 0, 0};
    for (int i = 0; i < 6; i++) begin
      bus.key_on = (i < 3) ? 4'b0001 : 4'b0000;
      run_sweep($sformatf("adsr%0d", i), exp_rel[i]);
    end

    // Dropped ticks: during the out_valid cycle and mid-sweep
    do_reset();
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    repeat (6) step();
    check("ovr.valid7", bus.out_valid, 1);
    check("ovr.clear", bus.overrun, 0);
    bus.sample_tick = 1'b1;
    step();
    check("ovr.drop7_busy", bus.busy, 0);
    check("ovr.drop7_flag", bus.overrun, 1);
    step();
    bus.sample_tick = 1'b0;
    check("ovr.accept8", bus.busy, 1);
    c = 9;
    while (!bus.out_valid && c < 40) begin
      step();
      c++;
    end
    check("ovr.valid_cycle", c, 15);

    do_reset();
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    step();
    step();
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    check("ovr.mid_flag", bus.overrun, 1);
    check("ovr.mid_busy", bus.busy, 1);
    repeat (6) step();

    // Phase wrap with the triangle waveform
    do_reset();
    cfg_write(0, 0, 24'hFFFFFF);
    cfg_write(0, 2, 2);
    cfg_write(0, 1, 16'hFFFF);
    cfg_write(0, 3, 16'hFFFF);
    bus.key_on = 4'b0001;
    run_sweep("tri_wrap1", -32768);
    run_sweep("tri_wrap2", -32768);

    // Asynchronous reset mid-sweep
    do_reset();
    setup_voice0_saw();
    bus.key_on = 4'b0001;
    run_sweep("pre_rst", -32512);
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    step();
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst.out", bus.out, 0);
    check("arst.valid", bus.out_valid, 0);
    check("arst.busy", bus.busy, 0);
    check("arst.overrun", bus.overrun, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    model_reset();
    setup_voice0_saw();
    run_sweep("post_rst", -32512);

    // Randomized configuration and gates against the model
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int exp;
      bit [N-1:0] keys;
      for (int w = 0; w < 4; w++) begin
        int addr = $urandom_range(0, 7);
        int data = (addr == 0) ? $urandom_range(0, 24'h03FFFF) : $urandom_range(0, 24'hFFFFFF);
        cfg_write($urandom_range(0, N - 1), addr, data);
      end
      keys       = N'($urandom_range(0, (1 << N) - 1));
      bus.key_on = keys;
      exp        = model_sweep(keys);
      run_sweep($sformatf("rnd%0d", it), exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
